// File: rtl/early_db_arbiter.sv
// Multi-channel early debouncer: the first synchronized edge passes at once, then the
// channel ignores its input for a tick-based hold. A round-robin arbiter reports db edges.
module early_db_arbiter #(
  parameter int N          = 4,
  parameter int TICK_DIV   = 100_000,
  parameter int HOLD_TICKS = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N-1:0]         sw,
  output logic [N-1:0]         db,
  output logic                 m_tick,
  output logic                 evt_valid,
  input  logic                 evt_ready,
  output logic [$clog2(N)-1:0] evt_id,
  output logic                 evt_edge,
  output logic                 evt_drop
);
  localparam int IW = $clog2(N);
  localparam int HW = $clog2(HOLD_TICKS + 1);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [1:0] {ST_ZERO, ST_WAIT1, ST_ONE, ST_WAIT0} state_t;

  logic [N-1:0]  r_sync1, r_sync2;
  logic [PW-1:0] r_presc;
  logic          r_tick;

  // NOTE: clocked state is always assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_presc <= '0;
      r_tick  <= 1'b0;
    end else begin
      r_sync1 <= sw;
      r_sync2 <= r_sync1;
      if (r_presc == PW'(TICK_DIV - 1)) begin
        r_presc <= '0;
        r_tick  <= 1'b1;
      end else begin
        r_presc <= r_presc + PW'(1);
        r_tick  <= 1'b0;
      end
    end
  end

  state_t        r_state     [N];
  state_t        w_state_nxt [N];
  logic [HW-1:0] r_cnt       [N];
  logic [HW-1:0] w_cnt_nxt   [N];
  logic [N-1:0]  r_db, w_db_nxt, w_tog;

  // NOTE: every combinational output gets a default before the case so no latch is inferred.
  always_comb begin
    w_db_nxt = '0;
    for (int i = 0; i < N; i++) begin
      w_state_nxt[i] = r_state[i];
      w_cnt_nxt[i]   = r_cnt[i];
      case (r_state[i])
        ST_ZERO: if (r_sync2[i]) begin
          w_state_nxt[i] = ST_WAIT1;
          w_cnt_nxt[i]   = HW'(HOLD_TICKS);
        end
        ST_ONE: if (!r_sync2[i]) begin
          w_state_nxt[i] = ST_WAIT0;
          w_cnt_nxt[i]   = HW'(HOLD_TICKS);
        end
        ST_WAIT1, ST_WAIT0: if (r_tick) begin
          if (r_cnt[i] <= HW'(1)) begin
            w_state_nxt[i] = (r_state[i] == ST_WAIT1) ? ST_ONE : ST_ZERO;
            w_cnt_nxt[i]   = '0;
          end else begin
            w_cnt_nxt[i] = r_cnt[i] - HW'(1);
          end
        end
        default: w_state_nxt[i] = ST_ZERO;
      endcase
      w_db_nxt[i] = (w_state_nxt[i] == ST_WAIT1) || (w_state_nxt[i] == ST_ONE);
    end
  end

  // NOTE: the per-channel state arrays are true flops, so they are reset element by element.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N; i++) begin
        r_state[i] <= ST_ZERO;
        r_cnt[i]   <= '0;
      end
      r_db <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        r_state[i] <= w_state_nxt[i];
        r_cnt[i]   <= w_cnt_nxt[i];
      end
      r_db <= w_db_nxt;
    end
  end

  assign w_tog = w_db_nxt ^ r_db;

  logic [N-1:0]  r_pend, r_pedge, w_acc;
  logic          r_valid, r_edge, r_drop, w_hs, w_found;
  logic [IW-1:0] r_id, r_ptr, w_sel, w_cidx;
  int            w_idx;

  assign w_hs = r_valid & evt_ready;

  // Search starts at the round-robin pointer and wraps past N-1 back to channel 0.
  always_comb begin
    w_acc   = '0;
    w_found = 1'b0;
    w_sel   = '0;
    w_idx   = 0;
    w_cidx  = '0;
    if (w_hs) w_acc[r_id] = 1'b1;
    for (int k = 0; k < N; k++) begin
      w_idx = int'(r_ptr) + k;
      if (w_idx >= N) w_idx = w_idx - N;
      w_cidx = IW'(w_idx);
      if (!w_found && r_pend[w_cidx]) begin
        w_found = 1'b1;
        w_sel   = w_cidx;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pend  <= '0;
      r_pedge <= '0;
      r_valid <= 1'b0;
      r_id    <= '0;
      r_edge  <= 1'b0;
      r_drop  <= 1'b0;
      r_ptr   <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (w_tog[i]) begin
          r_pend[i]  <= 1'b1;
          r_pedge[i] <= w_db_nxt[i];
        end else if (w_acc[i]) begin
          r_pend[i] <= 1'b0;
        end
      end
      // A new edge on a channel whose previous edge is still unaccepted loses that edge.
      if (|(w_tog & r_pend & ~w_acc)) r_drop <= 1'b1;
      if (r_valid) begin
        if (evt_ready) begin
          r_valid <= 1'b0;
          r_ptr   <= (r_id == IW'(N - 1)) ? '0 : r_id + IW'(1);
        end
      end else if (w_found) begin
        r_valid <= 1'b1;
        r_id    <= w_sel;
        r_edge  <= r_pedge[w_sel];
      end
    end
  end

  assign db        = r_db;
  assign m_tick    = r_tick;
  assign evt_valid = r_valid;
  assign evt_id    = r_id;
  assign evt_edge  = r_edge;
  assign evt_drop  = r_drop;
endmodule

// File: tb/tb_early_db_arbiter.sv
// Bench for early_db_arbiter: directed bounce/arbitration/reset scenarios plus random
// switch activity, all compared every cycle against a behavioural model.
module tb_early_db_arbiter;
  localparam int N  = 4;
  localparam int TD = 10;
  localparam int HT = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] sw = '0;
  logic         evt_ready = 1'b1;
  logic [N-1:0] db;
  logic         m_tick, evt_valid, evt_edge, evt_drop;
  logic [1:0]   evt_id;

  early_db_arbiter #(.N(N), .TICK_DIV(TD), .HOLD_TICKS(HT)) dut (
    .clk(clk), .reset(reset), .sw(sw), .db(db), .m_tick(m_tick),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_id(evt_id),
    .evt_edge(evt_edge), .evt_drop(evt_drop)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: switch history delayed two cycles, per-channel level plus
  // remaining hold ticks, a pending table and a presented-event record.
  logic [N-1:0] mdl_h1, mdl_h2, mdl_db;
  int           mdl_left [N];
  bit           mdl_pend [N];
  bit           mdl_pedge[N];
  int           mdl_cyc, mdl_id, mdl_ptr, mdl_old_id;
  bit           mdl_tick, mdl_valid, mdl_edge, mdl_drop;
  bit           mdl_hs, mdl_tick_seen, mdl_tr, mdl_found;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mdl_h1 = '0; mdl_h2 = '0; mdl_db = '0;
      mdl_cyc = 0; mdl_tick = 0;
      mdl_valid = 0; mdl_id = 0; mdl_edge = 0; mdl_drop = 0; mdl_ptr = 0;
      for (int i = 0; i < N; i++) begin
        mdl_left[i] = 0; mdl_pend[i] = 0; mdl_pedge[i] = 0;
      end
    end else begin
      mdl_hs        = mdl_valid && evt_ready;
      mdl_tick_seen = mdl_tick;
      mdl_old_id    = mdl_id;
      if (mdl_valid) begin
        if (mdl_hs) begin
          mdl_valid = 0;
          mdl_ptr   = (mdl_id + 1) % N;
        end
      end else begin
        mdl_found = 0;
        for (int k = 0; k < N; k++) begin
          if (!mdl_found && mdl_pend[(mdl_ptr + k) % N]) begin
            mdl_found = 1;
            mdl_valid = 1;
            mdl_id    = (mdl_ptr + k) % N;
            mdl_edge  = mdl_pedge[mdl_id];
          end
        end
      end
      for (int i = 0; i < N; i++) begin
        mdl_tr = 0;
        if (mdl_left[i] == 0) begin
          if (mdl_h2[i] != mdl_db[i]) begin
            mdl_db[i]   = mdl_h2[i];
            mdl_left[i] = HT;
            mdl_tr      = 1;
          end
        end else if (mdl_tick_seen) begin
          mdl_left[i] = mdl_left[i] - 1;
        end
        if (mdl_tr) begin
          if (mdl_pend[i] && !(mdl_hs && mdl_old_id == i)) mdl_drop = 1;
          mdl_pend[i]  = 1;
          mdl_pedge[i] = mdl_db[i];
        end else if (mdl_hs && mdl_old_id == i) begin
          mdl_pend[i] = 0;
        end
      end
      mdl_h2   = mdl_h1;
      mdl_h1   = sw;
      mdl_cyc  = mdl_cyc + 1;
      mdl_tick = (mdl_cyc % TD == 0);
    end
  end

  always @(negedge clk) begin
    check("db", 32'(db), 32'(mdl_db));
    check("m_tick", 32'(m_tick), 32'(mdl_tick));
    check("evt_valid", 32'(evt_valid), 32'(mdl_valid));
    check("evt_drop", 32'(evt_drop), 32'(mdl_drop));
    if (mdl_valid) begin
      check("evt_id", 32'(evt_id), 32'(mdl_id));
      check("evt_edge", 32'(evt_edge), 32'(mdl_edge));
    end
  end

  // Handshake log, sampled mid-cycle; the transfer happens on the following edge.
  typedef struct { int id; bit edg; int cyc; } hs_t;
  hs_t hs_q[$];
  int  tb_cyc = 0;
  always @(posedge clk) tb_cyc++;
  always @(negedge clk) if (reset && evt_valid && evt_ready)
    hs_q.push_back('{id: int'(evt_id), edg: evt_edge, cyc: tb_cyc});

  function automatic int q_id(input int k);
    return (k < hs_q.size()) ? hs_q[k].id : -1;
  endfunction
  function automatic int q_edge(input int k);
    return (k < hs_q.size()) ? int'(hs_q[k].edg) : -1;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick(3);
    reset = 1'b1;
    tick(1);
  endtask

  initial begin
    #1 reset = 1'b0;
    tick(3);
    check("rst_db", 32'(db), 0);
    check("rst_tick", 32'(m_tick), 0);
    check("rst_valid", 32'(evt_valid), 0);
    check("rst_id", 32'(evt_id), 0);
    check("rst_edge", 32'(evt_edge), 0);
    check("rst_drop", 32'(evt_drop), 0);
    reset = 1'b1;
    tick(5);

    // Press bounce on channel 0.
    hs_q.delete();
    sw[0] = 1'b1;
    tick(2);  check("bounce_pre", 32'(db[0]), 0);
    tick(1);  check("bounce_rise", 32'(db[0]), 1);
    tick(27); sw[0] = 1'b0;
    tick(15); sw[0] = 1'b1;
    tick(8);  sw[0] = 1'b0;
    tick(4);  sw[0] = 1'b1;
    tick(80);
    check("bounce_final", 32'(db[0]), 1);
    check("bounce_first_id", 32'(q_id(0)), 0);
    check("bounce_first_edge", 32'(q_edge(0)), 1);
    check("bounce_nodrop", 32'(evt_drop), 0);

    // Release bounce on channel 0 after a stable high.
    hs_q.delete();
    sw[0] = 1'b0;
    tick(2);  check("release_pre", 32'(db[0]), 1);
    tick(1);  check("release_fall", 32'(db[0]), 0);
    tick(4);  sw[0] = 1'b1;
    tick(5);  sw[0] = 1'b0;
    tick(60);
    check("release_count", 32'(hs_q.size()), 1);
    check("release_id", 32'(q_id(0)), 0);
    check("release_edge", 32'(q_edge(0)), 0);

    // Simultaneous channel 0/2 edges: rise from ptr=0, fall from ptr=3.
    do_reset();
    hs_q.delete();
    sw = 4'b0101;
    tick(60);
    check("rr_rise_n", 32'(hs_q.size()), 2);
    check("rr_rise_id0", 32'(q_id(0)), 0);
    check("rr_rise_id1", 32'(q_id(1)), 2);
    if (hs_q.size() >= 2) check("rr_rise_gap", 32'(hs_q[1].cyc - hs_q[0].cyc), 2);
    hs_q.delete();
    sw = 4'b0000;
    tick(60);
    check("rr_fall_id0", 32'(q_id(0)), 0);
    check("rr_fall_id1", 32'(q_id(1)), 2);
    check("rr_fall_e0", 32'(q_edge(0)), 0);

    // Backpressure on channel 1 across a full hold and a fall.
    do_reset();
    evt_ready = 1'b0;
    sw[1] = 1'b1;
    tick(3);  check("bp_valid_early", 32'(evt_valid), 0);
    tick(1);  check("bp_valid", 32'(evt_valid), 1);
    check("bp_id", 32'(evt_id), 1);
    check("bp_edge", 32'(evt_edge), 1);
    tick(45);
    check("bp_hold_valid", 32'(evt_valid), 1);
    check("bp_hold_nodrop", 32'(evt_drop), 0);
    sw[1] = 1'b0;
    tick(3);
    check("bp_fall_db", 32'(db[1]), 0);
    check("bp_drop", 32'(evt_drop), 1);
    check("bp_edge_stable", 32'(evt_edge), 1);
    tick(5);
    evt_ready = 1'b1;
    tick(1);  check("bp_accept", 32'(evt_valid), 0);
    tick(10);
    check("bp_drop_sticky", 32'(evt_drop), 1);

    // Asynchronous reset in the middle of a channel 3 hold.
    do_reset();
    sw[3] = 1'b1;
    tick(10);
    check("ar_db_before", 32'(db[3]), 1);
    #1 reset = 1'b0;
    #1;
    check("ar_db", 32'(db), 0);
    check("ar_valid", 32'(evt_valid), 0);
    check("ar_tick", 32'(m_tick), 0);
    check("ar_drop", 32'(evt_drop), 0);
    check("ar_id", 32'(evt_id), 0);
    tick(2);
    reset = 1'b1;
    tick(2);  check("ar_db_pre", 32'(db[3]), 0);
    tick(1);  check("ar_db_rise", 32'(db[3]), 1);
    tick(1);
    check("ar_evt_valid", 32'(evt_valid), 1);
    check("ar_evt_id", 32'(evt_id), 3);
    check("ar_evt_edge", 32'(evt_edge), 1);

    // Random switch activity with random back-pressure.
    do_reset();
    sw = '0;
    for (int seg = 0; seg < 15; seg++) begin
      int rate;
      rate = $urandom_range(4, 40);
      for (int c = 0; c < 200; c++) begin
        for (int i = 0; i < N; i++)
          if ($urandom_range(0, rate - 1) == 0) sw[i] = ~sw[i];
        evt_ready = ($urandom_range(0, 3) != 0);
        tick(1);
      end
    end
    sw = '0;
    evt_ready = 1'b1;
    tick(100);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end
endmodule
